control_sequencer: RTL and testbench

//  Hardwired Moore control unit for the single-bus SRC-style CPU. Consumes the 5-bit opcode from the IR.

---
 rtl/control_sequencer.sv | 177 +++++++++++++++++
 tb/tb_control_sequencer.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/control_sequencer.sv
// Hardwired Moore control unit for a single-bus SRC-style CPU: fetch T0-T3, opcode-driven execute T4-T8, HALT.
// Optional feature: define CTRL_BRL_EN to support brl (opcode 9); otherwise opcode 9 is flagged illegal.
module control_sequencer (
    input  logic       clk,
    input  logic       rst,
    input  logic [4:0] opcode,
    input  logic       mem_done,
    input  logic       cond,
    output logic       pc_out,
    output logic       pc_in,
    output logic       ma_in,
    output logic       md_in,
    output logic       md_out,
    output logic       md_rd,
    output logic       md_wr,
    output logic       ir_in,
    output logic       c1_out,
    output logic       c2_out,
    output logic       gra,
    output logic       grb,
    output logic       grc,
    output logic       r_in,
    output logic       r_out,
    output logic       ba_out,
    output logic       a_in,
    output logic       c_in,
    output logic       c_out,
    output logic       inc4,
    output logic       con_in,
    output logic [2:0] alu_op,
    output logic       halted,
    output logic       illegal
);

    typedef enum logic [3:0] {
        S_T0, S_T1, S_T2, S_T3, S_T4, S_T5, S_T6, S_T7, S_T8, S_HALT
    } state_t;

    typedef enum logic [3:0] {
        C_NOP, C_ALU, C_ALUI, C_LA, C_LAR, C_LD, C_ST, C_BR, C_BRL, C_STOP, C_ILL
    } cls_t;

    localparam logic [2:0] ALU_ADD = 3'd1;
    localparam logic [2:0] ALU_SUB = 3'd2;
    localparam logic [2:0] ALU_AND = 3'd3;
    localparam logic [2:0] ALU_OR  = 3'd4;

    state_t     r_state;
    cls_t       r_cls;
    logic [2:0] r_alu_op;
    state_t     w_next_state;
    cls_t       w_dec_cls;
    logic [2:0] w_dec_alu;
    cls_t       w_cls;
    logic [2:0] w_alu;

    always_comb begin
        w_dec_cls = C_ILL;
        w_dec_alu = 3'd0;
        case (opcode)
            5'd0:  w_dec_cls = C_NOP;
            5'd1:  begin w_dec_cls = C_LD;   w_dec_alu = ALU_ADD; end
            5'd3:  begin w_dec_cls = C_ST;   w_dec_alu = ALU_ADD; end
            5'd5:  begin w_dec_cls = C_LA;   w_dec_alu = ALU_ADD; end
            5'd6:  begin w_dec_cls = C_LAR;  w_dec_alu = ALU_ADD; end
            5'd8:  w_dec_cls = C_BR;
`ifdef CTRL_BRL_EN
            5'd9:  w_dec_cls = C_BRL;
`endif
            5'd12: begin w_dec_cls = C_ALU;  w_dec_alu = ALU_ADD; end
            5'd13: begin w_dec_cls = C_ALUI; w_dec_alu = ALU_ADD; end
            5'd14: begin w_dec_cls = C_ALU;  w_dec_alu = ALU_SUB; end
            5'd20: begin w_dec_cls = C_ALU;  w_dec_alu = ALU_AND; end
            5'd21: begin w_dec_cls = C_ALUI; w_dec_alu = ALU_AND; end
            5'd22: begin w_dec_cls = C_ALU;  w_dec_alu = ALU_OR;  end
            5'd23: begin w_dec_cls = C_ALUI; w_dec_alu = ALU_OR;  end
            5'd31: w_dec_cls = C_STOP;
            default: w_dec_cls = C_ILL;
        endcase
    end

    // The IR opcode only becomes valid in T4, so T4 decodes it live; later steps use the copy latched at T4.
    assign w_cls = (r_state == S_T4) ? w_dec_cls : r_cls;
    assign w_alu = (r_state == S_T4) ? w_dec_alu : r_alu_op;

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            S_T0: w_next_state = S_T1;
            S_T1: w_next_state = S_T2;
            S_T2: w_next_state = mem_done ? S_T3 : S_T2;
            S_T3: w_next_state = S_T4;
            S_T4: begin
                case (w_cls)
                    C_NOP, C_ILL: w_next_state = S_T0;
                    C_STOP:       w_next_state = S_HALT;
                    default:      w_next_state = S_T5;
                endcase
            end
            S_T5: w_next_state = (w_cls == C_BR) ? S_T0 : S_T6;
            S_T6: w_next_state = (w_cls == C_LD || w_cls == C_ST) ? S_T7 : S_T0;
            S_T7: w_next_state = (w_cls == C_ST || mem_done) ? S_T8 : S_T7;
            S_T8: w_next_state = (w_cls == C_LD || mem_done) ? S_T0 : S_T8;
            S_HALT: w_next_state = S_HALT;
            default: w_next_state = S_T0;
        endcase
    end

    // NOTE: state registers use non-blocking assignments so every flop samples the pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_T0;
            r_cls    <= C_NOP;
            r_alu_op <= 3'd0;
        end else begin
            r_state <= w_next_state;
            if (r_state == S_T4) begin
                r_cls    <= w_dec_cls;
                r_alu_op <= w_dec_alu;
            end
        end
    end

    // NOTE: every output gets a default before the case so no path leaves a latch behind.
    always_comb begin
        {pc_out, pc_in, ma_in, md_in, md_out, md_rd, md_wr}  = '0;
        {ir_in, c1_out, c2_out, gra, grb, grc, r_in, r_out}  = '0;
        {ba_out, a_in, c_in, c_out, inc4, con_in}            = '0;
        {halted, illegal}                                    = '0;
        alu_op = 3'd0;
        case (r_state)
            S_T0: {pc_out, ma_in, inc4, c_in} = 4'b1111;
            S_T1: {c_out, pc_in, md_rd} = 3'b111;
            S_T2: md_rd = 1'b1;
            S_T3: {md_out, ir_in} = 2'b11;
            S_T4: begin
                case (w_cls)
                    C_ALU, C_ALUI:      {grb, r_out, a_in} = 3'b111;
                    C_LA, C_LD, C_ST:   {grb, ba_out, a_in} = 3'b111;
                    C_LAR:              {pc_out, a_in} = 2'b11;
                    C_BR, C_BRL:        {grc, r_out, con_in} = 3'b111;
                    C_ILL:              illegal = 1'b1;
                    default: ;
                endcase
            end
            S_T5: begin
                case (w_cls)
                    C_ALU:  begin {grc, r_out, c_in} = 3'b111; alu_op = w_alu; end
                    C_ALUI, C_LA, C_LD, C_ST: begin {c2_out, c_in} = 2'b11; alu_op = w_alu; end
                    C_LAR:  begin {c1_out, c_in} = 2'b11; alu_op = w_alu; end
                    C_BR:   begin {grb, r_out} = 2'b11; pc_in = cond; end
                    C_BRL:  {pc_out, gra, r_in} = 3'b111;
                    default: ;
                endcase
            end
            S_T6: begin
                case (w_cls)
                    C_ALU, C_ALUI, C_LA, C_LAR: {c_out, gra, r_in} = 3'b111;
                    C_LD, C_ST:                 {c_out, ma_in} = 2'b11;
                    C_BRL:  begin {grb, r_out} = 2'b11; pc_in = cond; end
                    default: ;
                endcase
            end
            S_T7: begin
                if (w_cls == C_LD) md_rd = 1'b1;
                else               {gra, r_out, md_in} = 3'b111;
            end
            S_T8: begin
                if (w_cls == C_LD) {md_out, gra, r_in} = 3'b111;
                else               md_wr = 1'b1;
            end
            S_HALT: halted = 1'b1;
            default: ;
        endcase
    end

endmodule

// File: tb/tb_control_sequencer.sv
// Directed bench for control_sequencer: expected control vectors are queued per cycle and checked at negedge.
module tb_control_sequencer;

    logic       clk = 1'b0;
    logic       rst, mem_done, cond;
    logic [4:0] opcode;
    logic       pc_out, pc_in, ma_in, md_in, md_out, md_rd, md_wr;
    logic       ir_in, c1_out, c2_out, gra, grb, grc, r_in, r_out, ba_out;
    logic       a_in, c_in, c_out, inc4, con_in, halted, illegal;
    logic [2:0] alu_op;

    control_sequencer dut (
        .clk(clk), .rst(rst), .opcode(opcode), .mem_done(mem_done), .cond(cond),
        .pc_out(pc_out), .pc_in(pc_in), .ma_in(ma_in), .md_in(md_in), .md_out(md_out),
        .md_rd(md_rd), .md_wr(md_wr), .ir_in(ir_in), .c1_out(c1_out), .c2_out(c2_out),
        .gra(gra), .grb(grb), .grc(grc), .r_in(r_in), .r_out(r_out), .ba_out(ba_out),
        .a_in(a_in), .c_in(c_in), .c_out(c_out), .inc4(inc4), .con_in(con_in),
        .alu_op(alu_op), .halted(halted), .illegal(illegal)
    );

    always #5 clk = ~clk;

    localparam logic [25:0] PC_OUT = 26'd1 << 25, PC_IN = 26'd1 << 24, MA_IN = 26'd1 << 23;
    localparam logic [25:0] MD_IN  = 26'd1 << 22, MD_OUT = 26'd1 << 21, MD_RD = 26'd1 << 20;
    localparam logic [25:0] MD_WR  = 26'd1 << 19, IR_IN = 26'd1 << 18, C1 = 26'd1 << 17;
    localparam logic [25:0] C2     = 26'd1 << 16, GRA = 26'd1 << 15, GRB = 26'd1 << 14;
    localparam logic [25:0] GRC    = 26'd1 << 13, R_IN = 26'd1 << 12, R_OUT = 26'd1 << 11;
    localparam logic [25:0] BA     = 26'd1 << 10, A_IN = 26'd1 << 9, C_IN = 26'd1 << 8;
    localparam logic [25:0] C_OUT  = 26'd1 << 7, INC4 = 26'd1 << 6, CON_IN = 26'd1 << 5;
    localparam logic [25:0] HALTED = 26'd1 << 4, ILLEGAL = 26'd1 << 3;
    localparam logic [25:0] ADD = 26'd1, SUB = 26'd2, AND_ = 26'd3, OR_ = 26'd4;
    localparam logic [25:0] NONE = 26'd0;
    localparam logic [25:0] F0 = PC_OUT | MA_IN | INC4 | C_IN;
    localparam logic [25:0] F1 = C_OUT | PC_IN | MD_RD;
    localparam logic [25:0] F2 = MD_RD;
    localparam logic [25:0] F3 = MD_OUT | IR_IN;

    wire [25:0] obs = {pc_out, pc_in, ma_in, md_in, md_out, md_rd, md_wr, ir_in, c1_out, c2_out,
                       gra, grb, grc, r_in, r_out, ba_out, a_in, c_in, c_out, inc4, con_in,
                       halted, illegal, alu_op};

    typedef struct {
        logic [25:0] exp;
        string       tag;
    } sb_t;

    sb_t sb_q[$];
    int  n_tests = 0;
    int  n_fail  = 0;

    // One clock cycle: drive inputs, queue the expected vector, compare at negedge, return just after posedge.
    task automatic cyc(input logic [25:0] exp, input string tag, input logic rst_v,
                       input logic md_v, input logic cnd_v, input logic [4:0] op_v);
        sb_t e;
        sb_t got;
        rst = rst_v; mem_done = md_v; cond = cnd_v; opcode = op_v;
        e.exp = exp; e.tag = tag;
        sb_q.push_back(e);
        @(negedge clk);
        got = sb_q.pop_front();
        n_tests++;
        assert (obs === got.exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", got.tag, obs, got.exp);
        end
        @(posedge clk);
        #1;
    endtask

    // Fetch T0-T3; mem_done is high in T0/T1 (must be ignored) and the opcode bus carries junk until T4.
    task automatic fetch(input int waits, input string tag);
        cyc(F0, {tag, "_t0"}, 1'b0, 1'b1, 1'b0, 5'd31);
        cyc(F1, {tag, "_t1"}, 1'b0, 1'b1, 1'b0, 5'd31);
        for (int i = 0; i < waits; i++) cyc(F2, {tag, "_t2_wait"}, 1'b0, 1'b0, 1'b0, 5'd31);
        cyc(F2, {tag, "_t2_done"}, 1'b0, 1'b1, 1'b0, 5'd31);
        cyc(F3, {tag, "_t3"}, 1'b0, 1'b0, 1'b0, 5'd31);
    endtask

    initial begin
        rst = 1'b1; mem_done = 1'b0; cond = 1'b0; opcode = 5'd0;
        repeat (2) @(posedge clk);
        #1;

        // Reset in the middle of the instruction-fetch wait.
        cyc(F0, "rst_t0", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(F1, "rst_t1", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(F2, "rst_t2", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(F2, "rst_t2_hit", 1'b1, 1'b0, 1'b0, 5'd0);

        // add, one-cycle fetch wait; opcode changes after T4 must not matter.
        fetch(0, "add");
        cyc(GRB | R_OUT | A_IN,       "add_t4", 1'b0, 1'b1, 1'b0, 5'd12);
        cyc(GRC | R_OUT | C_IN | ADD, "add_t5", 1'b0, 1'b1, 1'b0, 5'd31);
        cyc(C_OUT | GRA | R_IN,       "add_t6", 1'b0, 1'b1, 1'b0, 5'd9);

        fetch(2, "sub");
        cyc(GRB | R_OUT | A_IN,       "sub_t4", 1'b0, 1'b0, 1'b0, 5'd14);
        cyc(GRC | R_OUT | C_IN | SUB, "sub_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(C_OUT | GRA | R_IN,       "sub_t6", 1'b0, 1'b0, 1'b0, 5'd0);

        fetch(0, "and");
        cyc(GRB | R_OUT | A_IN,        "and_t4", 1'b0, 1'b0, 1'b0, 5'd20);
        cyc(GRC | R_OUT | C_IN | AND_, "and_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(C_OUT | GRA | R_IN,        "and_t6", 1'b0, 1'b0, 1'b0, 5'd0);

        fetch(0, "ori");
        cyc(GRB | R_OUT | A_IN,  "ori_t4", 1'b0, 1'b0, 1'b0, 5'd23);
        cyc(C2 | C_IN | OR_,     "ori_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(C_OUT | GRA | R_IN,  "ori_t6", 1'b0, 1'b0, 1'b0, 5'd0);

        fetch(0, "la");
        cyc(GRB | BA | A_IN,     "la_t4", 1'b0, 1'b0, 1'b0, 5'd5);
        cyc(C2 | C_IN | ADD,     "la_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(C_OUT | GRA | R_IN,  "la_t6", 1'b0, 1'b0, 1'b0, 5'd0);

        fetch(0, "lar");
        cyc(PC_OUT | A_IN,       "lar_t4", 1'b0, 1'b0, 1'b0, 5'd6);
        cyc(C1 | C_IN | ADD,     "lar_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(C_OUT | GRA | R_IN,  "lar_t6", 1'b0, 1'b0, 1'b0, 5'd0);

        // ld with mem_done delayed three cycles in T7: md_rd high four cycles.
        fetch(0, "ld");
        cyc(GRB | BA | A_IN,     "ld_t4", 1'b0, 1'b1, 1'b0, 5'd1);
        cyc(C2 | C_IN | ADD,     "ld_t5", 1'b0, 1'b1, 1'b0, 5'd0);
        cyc(C_OUT | MA_IN,       "ld_t6", 1'b0, 1'b1, 1'b0, 5'd0);
        for (int i = 0; i < 3; i++) cyc(MD_RD, "ld_t7_wait", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(MD_RD,               "ld_t7_done", 1'b0, 1'b1, 1'b0, 5'd0);
        cyc(MD_OUT | GRA | R_IN, "ld_t8", 1'b0, 1'b1, 1'b0, 5'd0);

        // st: mem_done in T7 ignored, one extra wait cycle in T8.
        fetch(0, "st");
        cyc(GRB | BA | A_IN,      "st_t4", 1'b0, 1'b0, 1'b0, 5'd3);
        cyc(C2 | C_IN | ADD,      "st_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(C_OUT | MA_IN,        "st_t6", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(GRA | R_OUT | MD_IN,  "st_t7", 1'b0, 1'b1, 1'b0, 5'd0);
        cyc(MD_WR,                "st_t8_wait", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(MD_WR,                "st_t8_done", 1'b0, 1'b1, 1'b0, 5'd0);

        // br not taken, then taken.
        fetch(0, "br0");
        cyc(GRC | R_OUT | CON_IN, "br0_t4", 1'b0, 1'b0, 1'b0, 5'd8);
        cyc(GRB | R_OUT,          "br0_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        fetch(0, "br1");
        cyc(GRC | R_OUT | CON_IN, "br1_t4", 1'b0, 1'b0, 1'b0, 5'd8);
        cyc(GRB | R_OUT | PC_IN,  "br1_t5", 1'b0, 1'b0, 1'b1, 5'd0);

        // brl, or illegal opcode 9 when the feature is off.
        fetch(0, "op9");
`ifdef CTRL_BRL_EN
        cyc(GRC | R_OUT | CON_IN,  "brl_t4", 1'b0, 1'b0, 1'b0, 5'd9);
        cyc(PC_OUT | GRA | R_IN,   "brl_t5", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(GRB | R_OUT | PC_IN,   "brl_t6", 1'b0, 1'b0, 1'b1, 5'd0);
`else
        cyc(ILLEGAL,               "op9_illegal", 1'b0, 1'b0, 1'b0, 5'd9);
`endif

        // Unused opcode 2 and nop.
        fetch(0, "ill2");
        cyc(ILLEGAL, "ill2_t4", 1'b0, 1'b0, 1'b0, 5'd2);
        fetch(0, "nop");
        cyc(NONE,    "nop_t4",  1'b0, 1'b0, 1'b0, 5'd0);

        // stop: HALT holds for 100 cycles regardless of inputs, released only by rst.
        fetch(0, "stop");
        cyc(NONE, "stop_t4", 1'b0, 1'b0, 1'b0, 5'd31);
        for (int i = 0; i < 100; i++)
            cyc(HALTED, "halt_hold", 1'b0, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                5'($urandom_range(0, 31)));
        cyc(HALTED, "halt_rst", 1'b1, 1'b0, 1'b0, 5'd0);
        fetch(0, "post_halt");
        cyc(NONE, "post_halt_nop", 1'b0, 1'b0, 1'b0, 5'd0);
        cyc(F0,   "post_halt_t0",  1'b0, 1'b0, 1'b0, 5'd0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
